decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_core.sv | 16 +
 rtl/decoder.sv | 56 +++++
 tb/tb_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants and width helper for the binary-to-one-hot decoder
package decoder_pkg;

    localparam int IN_W_DEFAULT = 4;

    // Inactive output level in active-high polarity; the top flips it for one-cold builds.
    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int out_width(input int in_w);
        return 1 << in_w;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - combinational binary-to-one-hot conversion, no clock
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT
) (
    input  logic [IN_W-1:0]             code,
    output logic [out_width(IN_W)-1:0]  onehot
);

    localparam int OUT_W = out_width(IN_W);

    // Every code indexes a real bit, so no range guard is needed.
    assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << code;

endmodule

// File: rtl/decoder.sv
// rtl/decoder.sv - registered one-hot decoder with polarity select and sticky hit mask
module decoder
    import decoder_pkg::*;
#(
    parameter int IN_W       = IN_W_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        valid_in,
    input  logic [IN_W-1:0]             data_in,
    input  logic                        hit_clr,
    output logic [out_width(IN_W)-1:0]  data_out,
    output logic                        valid_out,
    output logic [out_width(IN_W)-1:0]  hit_mask
);

    localparam int OUT_W = out_width(IN_W);
    localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};
    localparam logic [OUT_W-1:0] IDLE     = {OUT_W{IDLE_LEVEL}} ^ POL_MASK;

    logic [OUT_W-1:0] onehot;
    logic             accept;

    decoder_core #(
        .IN_W (IN_W)
    ) u_core (
        .code   (data_in),
        .onehot (onehot)
    );

    assign accept = en & valid_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= IDLE;
            valid_out <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            data_out  <= valid_in ? (onehot ^ POL_MASK) : IDLE;
        end
    end

    // Clear is applied before the new hit is ORed in, so a same-cycle decode survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_mask <= '0;
        end else if (accept) begin
            hit_mask <= (hit_clr ? '0 : hit_mask) | onehot;
        end else if (hit_clr) begin
            hit_mask <= '0;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - self-checking bench for decoder, both output polarities
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        valid_in;
    logic [3:0]  data_in;
    logic        hit_clr;
    logic [15:0] data_out_h, hit_mask_h;
    logic        valid_out_h;
    logic [15:0] data_out_l, hit_mask_l;
    logic        valid_out_l;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last captured decode and the set of codes seen.
    bit exp_valid;
    int exp_code;
    bit seen [16];

    decoder #(.IN_W(4), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .data_in(data_in),
        .hit_clr(hit_clr), .data_out(data_out_h), .valid_out(valid_out_h), .hit_mask(hit_mask_h)
    );

    decoder #(.IN_W(4), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .data_in(data_in),
        .hit_clr(hit_clr), .data_out(data_out_l), .valid_out(valid_out_l), .hit_mask(hit_mask_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          v;
        logic [3:0]  d;
        bit          clr;
        logic [15:0] exp_data;
        bit          exp_vld;
        logic [15:0] exp_hit;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_data();
        logic [15:0] r;
        r = 16'h0;
        if (exp_valid) begin
            for (int k = 0; k < 16; k++) r[k] = (k == exp_code);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_hit();
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = seen[k];
        return r;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_code  = 0;
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
    endtask

    task automatic check_all();
        chk("data_h",  data_out_h, model_data());
        chk("data_l",  data_out_l, ~model_data());
        chk("valid_h", {15'h0, valid_out_h}, {15'h0, exp_valid});
        chk("valid_l", {15'h0, valid_out_l}, {15'h0, exp_valid});
        chk("hit_h",   hit_mask_h, model_hit());
        chk("hit_l",   hit_mask_l, model_hit());
        if (valid_out_h) chk("onehot_h", 16'($countones(data_out_h)), 16'd1);
        if (valid_out_l) chk("onecold_l", 16'($countones(~data_out_l)), 16'd1);
    endtask

    task automatic step(input bit e, input bit v, input logic [3:0] d, input bit c);
        en       = e;
        valid_in = v;
        data_in  = d;
        hit_clr  = c;
        @(posedge clk);
        #1;
        if (c) begin
            for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        end
        if (e) begin
            exp_valid = v;
            exp_code  = int'(d);
            if (v) seen[int'(d)] = 1'b1;
        end
        check_all();
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        valid_in = 1'b0;
        data_in  = 4'd0;
        hit_clr  = 1'b0;
        model_reset();

        vecs[0] = '{1, 1, 4'd5,  0, 16'h0020, 1, 16'h0020};
        vecs[1] = '{0, 1, 4'd9,  0, 16'h0020, 1, 16'h0020};
        vecs[2] = '{0, 0, 4'd3,  0, 16'h0020, 1, 16'h0020};
        vecs[3] = '{0, 1, 4'd7,  0, 16'h0020, 1, 16'h0020};
        vecs[4] = '{1, 0, 4'd2,  0, 16'h0000, 0, 16'h0020};
        vecs[5] = '{1, 1, 4'd0,  0, 16'h0001, 1, 16'h0021};
        vecs[6] = '{1, 1, 4'd15, 0, 16'h8000, 1, 16'h8021};
        vecs[7] = '{0, 1, 4'd3,  1, 16'h8000, 1, 16'h0000};
        vecs[8] = '{1, 1, 4'd7,  0, 16'h0080, 1, 16'h0080};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_h", data_out_h, 16'h0000);
        chk("rst_data_l", data_out_l, 16'hFFFF);
        chk("rst_valid",  {15'h0, valid_out_h}, 16'h0);
        chk("rst_hit",    hit_mask_h, 16'h0000);
        rst_n = 1'b1;

        // Hold, idle, boundary codes and clear-while-disabled.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].clr);
            chk("tbl_data",  data_out_h, vecs[i].exp_data);
            chk("tbl_valid", {15'h0, valid_out_h}, {15'h0, vecs[i].exp_vld});
            chk("tbl_hit",   hit_mask_h, vecs[i].exp_hit);
        end
        chk("pol_code0", vecs[5].exp_data ^ 16'hFFFF, 16'hFFFE);

        // Full sweep of every code.
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 4'(i), 0);
            chk("sweep_data", data_out_h, 16'h1 << i);
        end
        chk("sweep_hit", hit_mask_h, 16'hFFFF);

        // Build 16'h00FF then clear together with a decode of 15.
        step(1, 1, 4'd0, 1);
        for (int i = 1; i < 8; i++) step(1, 1, 4'(i), 0);
        chk("coll_pre", hit_mask_h, 16'h00FF);
        step(1, 1, 4'd15, 1);
        chk("coll_hit", hit_mask_h, 16'h8000);

        // Polarity: decode 0 on the one-cold build.
        step(1, 1, 4'd0, 0);
        chk("pol_data_l", data_out_l, 16'hFFFE);
        chk("pol_hit_l0", {15'h0, hit_mask_l[0]}, 16'h1);

        // Asynchronous reset between edges with a decode in flight.
        step(1, 1, 4'd10, 0);
        chk("ar_pre", data_out_h, 16'h0400);
        en = 1'b1; valid_in = 1'b1; data_in = 4'd3; hit_clr = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_data_h", data_out_h, 16'h0000);
        chk("ar_data_l", data_out_l, 16'hFFFF);
        chk("ar_valid",  {15'h0, valid_out_h}, 16'h0);
        chk("ar_hit",    hit_mask_h, 16'h0000);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        step(1, 1, 4'd12, 0);
        chk("ar_first", data_out_h, 16'h1000);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
